display_scan_driver: RTL and testbench

- Time-multiplexed scan driver for the board's NDIGITS-digit common-anode 7-segment display.
- Holds a 4·NDIGITS-bit hex value and cycles through the digits one at a time.
- For each digit it drives that digit's nibble onto bcd_out and pulls its anode low.
- Sits directly upstream of the nibble-to-segment decoder, which turns bcd_out into active-low cathodes.
- New values are double-buffered and only take effect at a frame boundary, so a digit never tears mid-scan.

---
 rtl/display_scan_driver.sv | 182 ++++++++++++++++++
 tb/tb_display_scan_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Time-multiplexed scan driver for an NDIGITS-digit common-anode 7-segment
//   display. One digit is lit at a time for DIGIT_TICKS cycles, followed by
//   BLANK_TICKS cycles with every anode off. The current digit's nibble goes
//   out on bcd_out toward the nibble-to-segment decoder.
//
//   A new value is loaded into a pending buffer. It is copied into the
//   displayed register only at a frame boundary, which is the advance from
//   digit NDIGITS-1 to digit 0. This keeps a frame from tearing mid-scan.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When it is defined, digit k>0 is dark whenever nibbles k..NDIGITS-1 of
//     the displayed value are all zero. Digit 0 always lights. Scan timing is
//     the same in both builds.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   value_in   in   [4*NDIGITS] hex value; nibble k drives digit k (0 = rightmost)
//   load       in   one-cycle strobe; captures value_in into the pending buffer
//   digit_en   in   [NDIGITS] per-digit enable; 0 keeps that anode high
//   bcd_out    out  [4] nibble of the current digit
//   anodes     out  [NDIGITS] active-low anode drives (one-cold or all ones)
//   frame_done out  one-cycle pulse at each frame boundary
//
// Handshake: load has no ready. Every cycle that load is high, value_in is
// accepted unconditionally. When several loads arrive before a boundary, the
// last one wins.
module display_scan_driver #(
  parameter int NDIGITS     = 8,
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value_in,
  input  logic                   load,
  input  logic [NDIGITS-1:0]     digit_en,
  output logic [3:0]             bcd_out,
  output logic [NDIGITS-1:0]     anodes,
  output logic                   frame_done
);

  localparam int MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int IW   = $clog2(NDIGITS);

  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t                 state, state_n;
  logic [IW-1:0]          idx, idx_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [4*NDIGITS-1:0]   display_reg, display_n;
  logic [4*NDIGITS-1:0]   pending_reg, pending_n;
  logic                   pending_valid, pending_valid_n;
  logic [3:0]             bcd_n;
  logic [NDIGITS-1:0]     anodes_n;
  logic                   frame_done_n;
  logic                   advance;
  logic [3:0]             nib_n;
  logic [NDIGITS-1:0]     suppress;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= BLANK;
      idx           <= IDX_LAST;
      cnt           <= '0;
      display_reg   <= '0;
      pending_reg   <= '0;
      pending_valid <= 1'b0;
      bcd_out       <= 4'h0;
      anodes        <= '1;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      cnt           <= cnt_n;
      display_reg   <= display_n;
      pending_reg   <= pending_n;
      pending_valid <= pending_valid_n;
      bcd_out       <= bcd_n;
      anodes        <= anodes_n;
      frame_done    <= frame_done_n;
    end
  end

  // Next-state, counter and buffer logic.
  always_comb begin
    state_n         = state;
    idx_n           = idx;
    cnt_n           = cnt + CW'(1);
    display_n       = display_reg;
    pending_n       = pending_reg;
    pending_valid_n = pending_valid;
    frame_done_n    = 1'b0;
    advance         = 1'b0;

    case (state)
      SHOW: begin
        if (cnt == DIGIT_LAST) begin
          cnt_n = '0;
          if (BLANK_TICKS > 0) state_n = BLANK;
          else                 advance = 1'b1;
        end
      end
      BLANK: begin
        // With BLANK_TICKS == 0 the only way into BLANK is reset, and the
        // scan leaves it on the first edge.
        if ((BLANK_TICKS == 0) || (cnt == BLANK_LAST)) begin
          cnt_n   = '0;
          advance = 1'b1;
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = '0;
      end
    endcase

    if (advance) begin
      state_n = SHOW;
      if (idx == IDX_LAST) begin
        idx_n        = '0;
        frame_done_n = 1'b1;
        if (pending_valid) begin
          display_n       = pending_reg;
          pending_valid_n = 1'b0;
        end
      end else begin
        idx_n = idx + IW'(1);
      end
    end

    // A load processed after the commit wins. A load on the boundary cycle
    // therefore becomes the next pending value, and the commit keeps the old one.
    if (load) begin
      pending_n       = value_in;
      pending_valid_n = 1'b1;
    end
  end

  // Nibble of the next digit, taken from the post-commit display value.
  always_comb begin
    nib_n = 4'h0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx_n == IW'(k)) nib_n = display_n[k*4 +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Scanning from the top down, a digit is dark while every nibble at or
  // above it is zero. Digit 0 always stays lit.
  logic all_zero;
  always_comb begin
    all_zero = 1'b1;
    suppress = '0;
    for (int k = NDIGITS - 1; k >= 1; k--) begin
      all_zero    = all_zero & (display_n[k*4 +: 4] == 4'h0);
      suppress[k] = all_zero;
    end
  end
`else
  assign suppress = '0;
`endif

  // Registered outputs. bcd_out changes only when the scan advances and holds
  // its value through the blanking interval.
  always_comb begin
    bcd_n    = advance ? nib_n : bcd_out;
    anodes_n = '1;
    if (state_n == SHOW) begin
      for (int k = 0; k < NDIGITS; k++) begin
        if (idx_n == IW'(k)) anodes_n[k] = ~(digit_en[k] & ~suppress[k]);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
module tb_display_scan_driver;

  localparam int ND = 8;
  localparam int DT = 4;
  localparam int BT = 2;
  localparam int SLOT = DT + BT;
  localparam int FP = ND * SLOT;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value_in = '0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic [3:0]  bcd_out;
  logic [7:0]  anodes;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_driver #(
    .NDIGITS(ND), .DIGIT_TICKS(DT), .BLANK_TICKS(BT)
  ) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load),
    .digit_en(digit_en), .bcd_out(bcd_out), .anodes(anodes),
    .frame_done(frame_done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge. Outputs are sampled 1 ns later. load is a one-edge strobe.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    load = 1'b0;
  endtask

  task automatic wait_frame(output int waited);
    waited = 0;
    while (frame_done !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    check("frame_wait_timeout", {31'b0, frame_done}, 32'd1);
  endtask

  // Records one full frame, starting on its frame_done sample. Each lit
  // digit's nibble is recorded along with which digits lit. The bench also
  // checks that a lit anode is one-cold, belongs to the slot's digit, and
  // falls in the first DT cycles of that slot. Optional loads are driven after
  // samples la1 and la2.
  task automatic capture(input int la1, input logic [31:0] lv1,
                         input int la2, input logic [31:0] lv2,
                         output logic [31:0] shown, output logic [7:0] lit);
    int bad_pos;
    int bad_fd;
    int d;
    int phase;
    logic [7:0] ea;
    bad_pos = 0;
    bad_fd = 0;
    shown = '0;
    lit = '0;
    for (int i = 0; i < FP; i++) begin
      if (i > 0) step();
      d = i / SLOT;
      phase = i % SLOT;
      ea = ~(8'd1 << d);
      if (anodes !== 8'hFF) begin
        if (phase >= DT || anodes !== ea) bad_pos++;
        shown[d*4 +: 4] = bcd_out;
        lit[d] = 1'b1;
      end
      if (frame_done !== (i == 0)) bad_fd++;
      if (i == la1) begin value_in = lv1; load = 1'b1; end
      if (i == la2) begin value_in = lv2; load = 1'b1; end
    end
    check("scan_position", bad_pos, 0);
    check("frame_done_pulse", bad_fd, 0);
  endtask

  task automatic frame_check(input string name, input int la1, input logic [31:0] lv1,
                             input int la2, input logic [31:0] lv2,
                             input logic [31:0] exp_val, input logic [7:0] exp_lit);
    logic [31:0] shown;
    logic [7:0]  lit;
    exp_q.push_back(exp_val);
    capture(la1, lv1, la2, lv2, shown, lit);
    check({name, "_value"}, shown, exp_q.pop_front());
    check({name, "_lit"}, {24'b0, lit}, {24'b0, exp_lit});
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int         edge_no;
    logic [7:0] an;
    logic [3:0] bcd;
    logic       fd;
  } vec_t;

  vec_t vt[12];
  int   w;

  initial begin
    // First-frame timing after reset release, with a load on cycle 0.
    vt[0]  = '{1,  8'hFF, 4'h0, 1'b0};
    vt[1]  = '{2,  8'hFE, 4'h8, 1'b1};
    vt[2]  = '{5,  8'hFE, 4'h8, 1'b0};
    vt[3]  = '{6,  8'hFF, 4'h8, 1'b0};
    vt[4]  = '{7,  8'hFF, 4'h8, 1'b0};
    vt[5]  = '{8,  8'hFD, 4'h7, 1'b0};
    vt[6]  = '{14, 8'hFB, 4'h6, 1'b0};
    vt[7]  = '{20, 8'hF7, 4'h5, 1'b0};
    vt[8]  = '{44, 8'h7F, 4'h1, 1'b0};
    vt[9]  = '{48, 8'hFF, 4'h1, 1'b0};
    vt[10] = '{49, 8'hFF, 4'h1, 1'b0};
    vt[11] = '{50, 8'hFE, 4'h8, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_anodes", {24'b0, anodes}, 32'hFF);
    check("reset_bcd", {28'b0, bcd_out}, 32'h0);
    check("reset_frame_done", {31'b0, frame_done}, 32'h0);

    reset = 1'b0;
    edge_n = 0;
    value_in = 32'h1234_5678;
    load = 1'b1;
    for (int v = 0; v < 12; v++) begin
      while (edge_n < vt[v].edge_no) step();
      check($sformatf("first_frame_anodes_e%0d", vt[v].edge_no), {24'b0, anodes}, {24'b0, vt[v].an});
      check($sformatf("first_frame_bcd_e%0d", vt[v].edge_no), {28'b0, bcd_out}, {28'b0, vt[v].bcd});
      check($sformatf("first_frame_fd_e%0d", vt[v].edge_no), {31'b0, frame_done}, {31'b0, vt[v].fd});
    end

    // Tear-free update. AAAA_AAAA is loaded while digit 3 shows and 0000_00C5
    // while digit 5 shows. This frame stays old, and AAAA is never displayed.
    frame_check("tear_free_current", 18, 32'hAAAA_AAAA, 30, 32'h0000_00C5, 32'h1234_5678, 8'hFF);
    wait_frame(w);
    check("frame_period", w, 1);
    // 2222 becomes pending mid-frame. 1111 is loaded on the boundary edge.
    frame_check("tear_free_next", 10, 32'h2222_2222, FP - 1, 32'h1111_1111, 32'h0000_00C5, 8'hFF);
    wait_frame(w);
    check("frame_period_2", w, 1);
    frame_check("boundary_old_pending", -1, 0, -1, 0, 32'h2222_2222, 8'hFF);
    wait_frame(w);
    frame_check("boundary_new_pending", -1, 0, -1, 0, 32'h1111_1111, 8'hFF);

    // Digit enable mask: digits 1 and 3 stay dark, and timing is unchanged.
    digit_en = 8'b1111_0101;
    wait_frame(w);
    check("frame_period_masked", w, 1);
    frame_check("digit_en_mask", -1, 0, -1, 0, 32'h1111_0101, 8'hF5);
    digit_en = 8'hFF;

    // Asynchronous reset mid-SHOW of digit 3, with a value still pending.
    wait_frame(w);
    value_in = 32'h9999_9999;
    load = 1'b1;
    repeat (3 * SLOT + 1) step();
    check("pre_reset_digit3", {24'b0, anodes}, 32'hF7);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_anodes", {24'b0, anodes}, 32'hFF);
    check("async_reset_bcd", {28'b0, bcd_out}, 32'h0);
    check("async_reset_fd", {31'b0, frame_done}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_frame(w);
    check("first_show_after_reset", w, BT);
    frame_check("after_reset_zero", 5, 32'h0000_0030, -1, 0, 32'h0000_0000, 8'hFF);

    // Leading-zero blanking: only visible when the feature is built in.
    wait_frame(w);
`ifdef LEADING_ZERO_BLANK_EN
    frame_check("lzb_value_30", 5, 32'h0000_0000, -1, 0, 32'h0000_0030, 8'h03);
    wait_frame(w);
    frame_check("lzb_value_0", -1, 0, -1, 0, 32'h0000_0000, 8'h01);
`else
    frame_check("lzb_value_30", 5, 32'h0000_0000, -1, 0, 32'h0000_0030, 8'hFF);
    wait_frame(w);
    frame_check("lzb_value_0", -1, 0, -1, 0, 32'h0000_0000, 8'hFF);
`endif

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
